fifo_status: RTL and testbench

- Occupancy tracker and flag generator for the systolic-array input/output FIFOs.
- Sits directly upstream of read_pointer and beside write_pointer:
  - its registered fifo_empty feeds read_pointer's fifo_empty input;
  - its registered fifo_full gates write_pointer.
- Uses the same raw read/write requests as the pointer blocks and tracks level with a counter; pointers carry no wrap bit.
- Also provides almost-full/almost-empty thresholds and sticky overflow/underflow error flags for the array controller.

---
 rtl/fifo_status.sv | 83 ++++++++
 tb/tb_fifo_status.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_status.sv
// Level counter and flag generator for the systolic-array FIFOs.
// All outputs are registered and derived from the next level.
module fifo_status #(
  parameter int PTR_LENGTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clr_err,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PTR_LENGTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int LW = PTR_LENGTH + 1;
  localparam int DEPTH = 2 ** PTR_LENGTH;
  localparam logic [PTR_LENGTH:0] DEPTH_L = LW'(DEPTH);
  localparam logic [PTR_LENGTH:0] AF_L    = LW'(AF_THRESH);
  localparam logic [PTR_LENGTH:0] AE_L    = LW'(AE_THRESH);

  logic [PTR_LENGTH:0] level_q, level_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                aempty_q, aempty_d;
  logic                afull_q, afull_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                acc_wr, acc_rd;

  // Accept terms use the registered flags so they match the pointer blocks.
  always_comb begin
    acc_wr  = write & ~full_q;
    acc_rd  = read & ~empty_q;
    level_d = level_q;
    if (acc_wr && !acc_rd)
      level_d = level_q + 1'b1;
    else if (acc_rd && !acc_wr)
      level_d = level_q - 1'b1;
    empty_d  = (level_d == '0);
    full_d   = (level_d == DEPTH_L);
    aempty_d = (level_d <= AE_L);
    afull_d  = (level_d >= AF_L);
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~clr_err) | (write & full_q);
    unf_d = (unf_q & ~clr_err) | (read & empty_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= (AF_THRESH == 0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign level        = level_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: directed scenarios plus a randomized
// run against a behavioural occupancy/pointer model.
module tb_fifo_status;

  localparam int PTR_LENGTH = 5;
  localparam int DEPTH = 2 ** PTR_LENGTH;
  localparam int AF = 28;
  localparam int AE = 4;
  localparam int LW = PTR_LENGTH + 1;

  logic clk, reset_n, write, read, clr_err;
  logic fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow;
  logic [PTR_LENGTH:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy count, sticky bits and free-running pointers.
  int m_level, m_wptr, m_rptr;
  bit m_ovf, m_unf;

  fifo_status #(.PTR_LENGTH(PTR_LENGTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .read(read), .clr_err(clr_err),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input bit rn, input bit w, input bit r, input bit c);
    bit full, empty, aw, ar;
    reset_n = rn; write = w; read = r; clr_err = c;
    @(posedge clk);
    if (!rn) begin
      m_level = 0; m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full  = (m_level == DEPTH);
      empty = (m_level == 0);
      aw = w && !full;
      ar = r && !empty;
      if (aw) m_wptr = (m_wptr + 1) % DEPTH;
      if (ar) m_rptr = (m_rptr + 1) % DEPTH;
      m_level = m_level + int'(aw) - int'(ar);
      m_ovf = (m_ovf && !c) || (w && full);
      m_unf = (m_unf && !c) || (r && empty);
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b expected 1", almost_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", underflow); end
    $display("test_reset: level=%0d empty=%b", level, fifo_empty);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 1, 0, 0);
      checks++; if (level !== LW'(i)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", level, i); end
      checks++; if (almost_empty !== (i <= AE)) begin errors++; $display("FAIL fill_aempty at %0d: got %b expected %b", i, almost_empty, (i <= AE)); end
      checks++; if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_afull at %0d: got %b expected %b", i, almost_full, (i >= AF)); end
      checks++; if (fifo_full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full at %0d: got %b expected %b", i, fifo_full, (i == DEPTH)); end
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL fill_empty at %0d: got %b expected 0", i, fifo_empty); end
    end
    $display("test_fill: level=%0d full=%b afull=%b", level, fifo_full, almost_full);
  endtask

  task automatic test_full_rw();
    step(1, 1, 1, 0);
    checks++; if (level !== LW'(DEPTH - 1)) begin errors++; $display("FAIL fullrw_level: got %0d expected %0d", level, DEPTH - 1); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fullrw_full: got %b expected 0", fifo_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullrw_ovf: got %b expected 1", overflow); end
    step(1, 1, 0, 0);
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL refill_level: got %0d expected %0d", level, DEPTH); end
    step(1, 1, 0, 0);
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL hold_level: got %0d expected %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL hold_ovf: got %b expected 1", overflow); end
    $display("test_full_rw: level=%0d overflow=%b", level, overflow);
  endtask

  task automatic test_underflow();
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set: got %b expected 1", underflow); end
    checks++; if (level !== '0) begin errors++; $display("FAIL unf_level: got %0d expected 0", level); end
    step(1, 0, 1, 1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_clr_collide: got %b expected 1", underflow); end
    step(1, 0, 0, 1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr: got %b expected 0", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL unf_ovf: got %b expected 0", overflow); end
    // Empty with write and read together: write wins, underflow still flags.
    step(1, 1, 1, 0);
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL empty_rw_level: got %0d expected 1", level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_unf: got %b expected 1", underflow); end
    $display("test_underflow: level=%0d underflow=%b", level, underflow);
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0);
      checks++; if (level !== LW'(10)) begin errors++; $display("FAIL b2b_level: got %0d expected 10", level); end
      checks++; if ({fifo_empty, fifo_full, almost_empty, almost_full} !== 4'b0000) begin
        errors++; $display("FAIL b2b_flags: got %b expected 0000", {fifo_empty, fifo_full, almost_empty, almost_full}); end
      checks++; if (((m_wptr - m_rptr + DEPTH) % DEPTH) !== (int'(level) % DEPTH)) begin
        errors++; $display("FAIL b2b_ptr: got %0d expected %0d", int'(level) % DEPTH, (m_wptr - m_rptr + DEPTH) % DEPTH); end
    end
    $display("test_back_to_back: level=%0d wptr=%0d rptr=%0d", level, m_wptr, m_rptr);
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 0, 0);
    for (int i = 0; i < DEPTH - 20; i++) step(1, 0, 1, 0);
    checks++; if (level !== LW'(20) || overflow !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got level %0d ovf %b expected 20 1", level, overflow); end
    step(0, 1, 0, 0);
    checks++; if (level !== '0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", fifo_empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
    step(1, 0, 0, 0);
    checks++; if (level !== '0) begin errors++; $display("FAIL mid_after: got %0d expected 0", level); end
    $display("test_reset_mid: level=%0d overflow=%b", level, overflow);
  endtask

  task automatic test_random();
    int errs0;
    errs0 = errors;
    step(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit rn, w, r, c;
      int phase;
      phase = (n / 300) % 3;  // alternate fill-biased, drain-biased and balanced phases
      rn = ($urandom_range(0, 199) != 0);
      w  = (phase == 0) ? ($urandom_range(0, 9) < 8) : (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
      r  = (phase == 1) ? ($urandom_range(0, 9) < 8) : (phase == 0) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
      c  = ($urandom_range(0, 19) == 0);
      step(rn, w, r, c);
      checks++;
      if (level !== LW'(m_level) || fifo_empty !== (m_level == 0) || fifo_full !== (m_level == DEPTH) ||
          almost_empty !== (m_level <= AE) || almost_full !== (m_level >= AF) ||
          overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL random cycle %0d: got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b expected lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b",
                 n, level, fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow,
                 m_level, (m_level == 0), (m_level == DEPTH), (m_level <= AE), (m_level >= AF), m_ovf, m_unf);
      end
      checks++;
      if (((m_wptr - m_rptr + DEPTH) % DEPTH) !== (int'(level) % DEPTH)) begin
        errors++;
        $display("FAIL random_ptr cycle %0d: got %0d expected %0d", n, int'(level) % DEPTH, (m_wptr - m_rptr + DEPTH) % DEPTH);
      end
    end
    $display("test_random: 3000 cycles, %0d new errors", errors - errs0);
  endtask

  initial begin
    reset_n = 0; write = 0; read = 0; clr_err = 0;
    m_level = 0; m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_fill();
    test_full_rw();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
